// File: rtl/truth_table_checker_if.sv
// Bus between the truth-table checker and the environment that owns start/abort
// and the gate output y. slave = checker side, master = driver/observer side.
interface truth_table_checker_if;
  logic       start;
  logic       abort;
  logic       y;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [7:0] fail_mask;
  logic [2:0] first_fail;
  logic       first_fail_vld;

  modport slave (
    input  start, abort, y,
    output a, b, c, busy, done, pass, err_cnt, fail_mask, first_fail, first_fail_vld
  );

  modport master (
    output start, abort, y,
    input  a, b, c, busy, done, pass, err_cnt, fail_mask, first_fail, first_fail_vld
  );
endinterface

// File: rtl/truth_table_checker.sv
// Sweeps all eight {a,b,c} vectors into a 3-input gate, samples y after SETTLE
// cycles per vector and scores it against the golden table TRUTH.
module truth_table_checker #(
  parameter logic [7:0] TRUTH  = 8'h17,
  parameter int         SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [2:0] idx;
  logic [2:0] vec;
  logic [3:0] cnt;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_cnt_q;
  logic [7:0] fail_mask_q;
  logic [2:0] first_fail_q;
  logic       first_fail_vld_q;

  // NOTE: all state, including the result registers, uses non-blocking
  // assignments under the async reset so every output is a clean flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= '0;
      vec              <= '0;
      cnt              <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= '0;
      fail_mask_q      <= '0;
      first_fail_q     <= '0;
      first_fail_vld_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // start beats a simultaneous abort here simply because abort is not looked at
          if (bus.start) begin
            state            <= DRIVE;
            idx              <= '0;
            vec              <= '0;
            cnt              <= '0;
            busy_q           <= 1'b1;
            pass_q           <= 1'b0;
            err_cnt_q        <= '0;
            fail_mask_q      <= '0;
            first_fail_q     <= '0;
            first_fail_vld_q <= 1'b0;
          end
        end

        DRIVE: begin
          if (bus.abort) begin
            state  <= IDLE;
            vec    <= '0;
            busy_q <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            if (bus.y != TRUTH[idx]) begin
              fail_mask_q[idx] <= 1'b1;
              err_cnt_q        <= err_cnt_q + 4'd1;
              if (!first_fail_vld_q) begin
                first_fail_q     <= idx;
                first_fail_vld_q <= 1'b1;
              end
            end
            cnt <= '0;
            if (idx == 3'd7) begin
              state  <= DONE;
              vec    <= '0;
              busy_q <= 1'b0;
            end else begin
              idx <= idx + 3'd1;
              vec <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        DONE: begin
          // fail_mask already holds the vector-7 result by the time we get here
          done_q <= 1'b1;
          pass_q <= (fail_mask_q == 8'h00);
          vec    <= '0;
          idx    <= '0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a              = vec[2];
  assign bus.b              = vec[1];
  assign bus.c              = vec[0];
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_cnt        = err_cnt_q;
  assign bus.fail_mask      = fail_mask_q;
  assign bus.first_fail     = first_fail_q;
  assign bus.first_fail_vld = first_fail_vld_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench: the gate under check is a programmable 8-entry table,
// results are predicted from the XOR of that table with the golden minority table.
module tb_truth_table_checker;

  localparam logic [7:0] GOLD   = 8'h17;
  localparam int         SETTLE = 2;

  logic clk;
  logic rst_n;
  logic [7:0] dut_tt;

  int n_tests = 0;
  int n_fail  = 0;

  truth_table_checker_if bus ();

  truth_table_checker #(.TRUTH(GOLD), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.y = dut_tt[{bus.a, bus.b, bus.c}];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: score each vector of the modelled gate against the golden table.
  task automatic predict(input logic [7:0] tt, output logic [7:0] mask, output logic [3:0] errs,
                         output logic [2:0] first, output logic first_vld);
    mask = '0; errs = '0; first = '0; first_vld = 1'b0;
    for (int v = 0; v < 8; v++) begin
      if (tt[v] != GOLD[v]) begin
        mask[v] = 1'b1;
        errs    = errs + 4'd1;
        if (!first_vld) begin
          first     = 3'(v);
          first_vld = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_abc"},   {29'd0, bus.a, bus.b, bus.c}, 32'd0);
    check({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
    check({tag, "_done"},  {31'd0, bus.done}, 32'd0);
    check({tag, "_pass"},  {31'd0, bus.pass}, 32'd0);
    check({tag, "_err"},   {28'd0, bus.err_cnt}, 32'd0);
    check({tag, "_mask"},  {24'd0, bus.fail_mask}, 32'd0);
    check({tag, "_first"}, {28'd0, bus.first_fail_vld, bus.first_fail}, 32'd0);
  endtask

  // Full sweep with the vector sequence and done latency checked cycle by cycle.
  task automatic run_sweep(input string tag, input logic [7:0] tt, input bit abort_too);
    logic [7:0] e_mask;
    logic [3:0] e_err;
    logic [2:0] e_first;
    logic       e_vld;
    bit         seq_ok;
    predict(tt, e_mask, e_err, e_first, e_vld);
    dut_tt    = tt;
    bus.start = 1'b1;
    bus.abort = abort_too;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    seq_ok = 1'b1;
    for (int k = 0; k < 8 * SETTLE; k++) begin
      if ({bus.a, bus.b, bus.c} !== 3'(k / SETTLE) || bus.busy !== 1'b1 || bus.done !== 1'b0)
        seq_ok = 1'b0;
      tick();
    end
    check({tag, "_sequence"}, {31'd0, seq_ok}, 32'd1);
    check({tag, "_busy_fall"}, {30'd0, bus.busy, bus.done}, 32'd0);
    tick();
    check({tag, "_done"},  {31'd0, bus.done}, 32'd1);
    check({tag, "_abc0"},  {29'd0, bus.a, bus.b, bus.c}, 32'd0);
    check({tag, "_mask"},  {24'd0, bus.fail_mask}, {24'd0, e_mask});
    check({tag, "_err"},   {28'd0, bus.err_cnt}, {28'd0, e_err});
    check({tag, "_first"}, {28'd0, bus.first_fail_vld, bus.first_fail}, {28'd0, e_vld, e_first});
    check({tag, "_pass"},  {31'd0, bus.pass}, {31'd0, (e_mask == 8'h00)});
    tick();
    check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_hold"}, {19'd0, bus.pass, bus.err_cnt, bus.fail_mask},
          {19'd0, (e_mask == 8'h00), e_err, e_mask});
  endtask

  initial begin
    bit seq_ok;
    logic [7:0] r_tt;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    dut_tt    = GOLD;
    #2;
    check_outputs_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();

    run_sweep("ideal",     8'h17, 1'b0);
    run_sweep("y0",        8'h00, 1'b0);
    run_sweep("y1",        8'hFF, 1'b0);
    run_sweep("majority",  8'hE8, 1'b0);
    run_sweep("last_only", 8'h97, 1'b0);
    run_sweep("start_abort_same", 8'h17, 1'b1);
    for (int i = 0; i < 6; i++) begin
      r_tt = 8'($urandom);
      run_sweep($sformatf("rand%0d", i), r_tt, 1'b0);
    end

    // Abort at idx=3 with a stray start pulse while busy.
    dut_tt    = GOLD;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seq_ok = 1'b1;
    for (int k = 0; k < 3 * SETTLE; k++) begin
      bus.start = (k == 2);
      if ({bus.a, bus.b, bus.c} !== 3'(k / SETTLE) || bus.busy !== 1'b1) seq_ok = 1'b0;
      tick();
    end
    bus.start = 1'b0;
    check("abort_start_ignored", {31'd0, seq_ok}, 32'd1);
    check("abort_idx3", {29'd0, bus.a, bus.b, bus.c}, 32'd3);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_abc0", {30'd0, {bus.a, bus.b, bus.c} == 3'd0, bus.busy}, 32'd2);
    seq_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (bus.done !== 1'b0 || bus.pass !== 1'b0) seq_ok = 1'b0;
      tick();
    end
    check("abort_no_done", {31'd0, seq_ok}, 32'd1);
    run_sweep("after_abort", 8'h17, 1'b0);

    // Asynchronous reset in the middle of a failing sweep.
    dut_tt    = 8'h00;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    run_sweep("after_reset", 8'h17, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Self-checking response monitor for small combinational gate blocks such as the 3-input minority gate. It drives all eight input vectors into the device under test, waits a programmable settle time, samples the single output and compares it against a golden truth table held as a parameter. Results are a per-vector mismatch mask, an error count, the first failing vector and a pass flag. It sits beside the gate in hardware self-test builds and in the simulation environment, and closes the loop that a display-only stimulus bench leaves open.

## Interface

Parameters:

- TRUTH, 8'h17, golden output per vector; bit i is expected y for vector index i = {a,b,c}, a is MSB. The default is the minority function.
- SETTLE, 2, cycles each vector is held before y is sampled; legal range 1..15.

Ports:

- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin a sweep; honoured only in IDLE
- abort  input  1  synchronous cancel of a running sweep
- y  input  1  DUT output under check
- a, b, c  output  1 each  registered DUT inputs
- busy  output  1  high in DRIVE
- done  output  1  one-cycle pulse at sweep completion
- pass  output  1  high when the last completed sweep had zero mismatches
- err_cnt  output  4  mismatches in the last sweep, 0..8
- fail_mask  output  8  bit i set if vector i mismatched
- first_fail  output  3  lowest failing vector index
- first_fail_vld  output  1  first_fail is meaningful

## Operation

- States: IDLE, DRIVE, DONE.
- IDLE to DRIVE on start=1. On the same edge:
  - idx is set to 0 and the settle counter to 0.
  - fail_mask, err_cnt, first_fail, first_fail_vld and pass are cleared.
  - {a,b,c} is driven to 3'b000.
- In DRIVE, {a,b,c} is always equal to idx.
- The settle counter increments each cycle. On the edge where the counter equals SETTLE-1:
  - y is compared with TRUTH[idx].
  - On a mismatch, fail_mask[idx] is set and err_cnt increments.
  - If first_fail_vld was 0, first_fail is set to idx and first_fail_vld to 1.
  - If idx<7, idx and {a,b,c} advance by 1 and the counter returns to 0.
  - If idx==7, the next state is DONE.
- DONE lasts one cycle:
  - done=1.
  - pass is set to (fail_mask==0) using the final mask, including the vector-7 result.
  - {a,b,c} returns to 0.
  - The next state is IDLE.
- idx wraps only through DONE. Vectors are never skipped or repeated.
- start in DRIVE or DONE is ignored.
- abort in DRIVE:
  - Next state is IDLE and {a,b,c} goes to 0.
  - done is not pulsed and pass stays 0.
  - Partial fail_mask and err_cnt are held.
- abort in IDLE or DONE has no effect.
- If start and abort arrive together in IDLE, start wins.

## Timing

- Reset values: all outputs 0 and state IDLE. Asserting rst_n low mid-sweep forces this immediately, without waiting for a clock edge.
- Vector k appears on {a,b,c} on the edge ending cycle 1+k·SETTLE after start is sampled, and is held for exactly SETTLE cycles.
- y is sampled SETTLE cycles after its vector is applied. The DUT combinational path must settle within that window.
- busy rises on the edge after start is sampled and stays high for 8·SETTLE cycles.
- done pulses on the cycle immediately after busy falls. Total latency from start to done is 8·SETTLE+1 cycles.
- pass, err_cnt, fail_mask and first_fail are stable from done until the next accepted start.

## Test plan

- Ideal minority model on y, SETTLE=2, start pulse:
  - {a,b,c} steps 000..111 every 2 cycles.
  - done arrives 17 cycles after start.
  - pass=1, err_cnt=0, fail_mask=8'h00, first_fail_vld=0.
- y tied to 0:
  - fail_mask=8'h17, err_cnt=4, first_fail=0, first_fail_vld=1, pass=0.
- y tied to 1:
  - fail_mask=8'hE8, err_cnt=4, first_fail=3, pass=0.
- Majority model instead of minority (inverted output):
  - fail_mask=8'hFF, err_cnt=8, first_fail=0, pass=0.
- Ideal model, abort asserted while idx=3, then a new start; also a start pulse while busy:
  - Abort: no done, {a,b,c}=000 next cycle, pass=0.
  - Start while busy: ignored.
  - Fresh sweep after the new start: pass=1.
- rst_n low mid-sweep while y is tied to 0, then a restart with the ideal model:
  - While rst_n is low, all outputs are 0 immediately.
  - After release and start: clean sweep, err_cnt=0, pass=1.
